// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with delay-slot redirect timing, stall-held redirects,
// and exception/ERET override. Every output is registered.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic        pending_o,
    output logic        flush_o,
    output logic        adel_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic [31:0] pc_nxt;
    logic        flush_nxt;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        pc_nxt       = pc_o;
        state_nxt    = state;
        pend_tgt_nxt = pend_tgt;
        flush_nxt    = 1'b0;

        if (exc_req_i) begin
            pc_nxt    = EXC_VECTOR;
            flush_nxt = 1'b1;
            state_nxt = ST_RUN;
        end else if (eret_req_i) begin
            pc_nxt    = epc_i;
            flush_nxt = 1'b1;
            state_nxt = ST_RUN;
        end else if (stall_i) begin
            // PC holds; the newest redirect seen during the stall is the one kept.
            if (redirect_i) begin
                pend_tgt_nxt = redirect_target_i;
                state_nxt    = ST_HOLD;
            end
        end else if (state == ST_HOLD) begin
            pc_nxt    = redirect_i ? redirect_target_i : pend_tgt;
            state_nxt = ST_RUN;
        end else begin
            // Redirect arrives while the delay slot is already in IF, so it lands next edge.
            pc_nxt = redirect_i ? redirect_target_i : pc_o + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (reset) begin
            pc_o     <= RESET_PC;
            state    <= ST_RUN;
            pend_tgt <= 32'h0;
            flush_o  <= 1'b0;
            adel_o   <= 1'b0;
        end else begin
            pc_o     <= pc_nxt;
            state    <= state_nxt;
            pend_tgt <= pend_tgt_nxt;
            flush_o  <= flush_nxt;
            adel_o   <= (pc_nxt[1:0] != 2'b00);
        end
    end

    assign pending_o = (state == ST_HOLD);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: hand-computed PC/flag sequences.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic        pending_o;
    logic        flush_o;
    logic        adel_o;

    int n_checks = 0;
    int n_errors = 0;

    pc_redirect_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .exc_req_i         (exc_req_i),
        .eret_req_i        (eret_req_i),
        .epc_i             (epc_i),
        .pc_o              (pc_o),
        .pending_o         (pending_o),
        .flush_o           (flush_o),
        .adel_o            (adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks pc plus the three flags in one go.
    task automatic expect_state(input string tag, input logic [31:0] pc, input logic pend,
                                input logic fl, input logic ad);
        check({tag, ".pc"},      pc_o,      pc);
        check({tag, ".pending"}, {31'b0, pending_o}, {31'b0, pend});
        check({tag, ".flush"},   {31'b0, flush_o},   {31'b0, fl});
        check({tag, ".adel"},    {31'b0, adel_o},    {31'b0, ad});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 32'h0;
        exc_req_i = 1'b0; eret_req_i = 1'b0; epc_i = 32'h0;
        #1;
        step(); step();
        expect_state("reset", 32'h3000, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        step(); expect_state("run1", 32'h3004, 1'b0, 1'b0, 1'b0);
        step(); expect_state("run2", 32'h3008, 1'b0, 1'b0, 1'b0);
        step(); expect_state("run3", 32'h300C, 1'b0, 1'b0, 1'b0);
        step(); check("run4.pc", pc_o, 32'h3010);

        redirect_i = 1'b1; redirect_target_i = 32'h3100;
        step(); expect_state("redir", 32'h3100, 1'b0, 1'b0, 1'b0);
        redirect_i = 1'b0;
        step(); check("redir_seq.pc", pc_o, 32'h3104);

        redirect_i = 1'b1; redirect_target_i = 32'h3020;
        step(); check("to3020.pc", pc_o, 32'h3020);

        // Stall three cycles, redirects on the first and third; newest wins.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h3200;
        step(); expect_state("stall1", 32'h3020, 1'b1, 1'b0, 1'b0);
        redirect_i = 1'b0;
        step(); expect_state("stall2", 32'h3020, 1'b1, 1'b0, 1'b0);
        redirect_i = 1'b1; redirect_target_i = 32'h3300;
        step(); expect_state("stall3", 32'h3020, 1'b1, 1'b0, 1'b0);
        stall_i = 1'b0; redirect_i = 1'b0;
        step(); expect_state("release", 32'h3300, 1'b0, 1'b0, 1'b0);

        // Exception while holding a redirect, stall still asserted.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h3500;
        step(); expect_state("hold_again", 32'h3300, 1'b1, 1'b0, 1'b0);
        redirect_i = 1'b0; exc_req_i = 1'b1;
        step(); expect_state("exc", 32'h4180, 1'b0, 1'b1, 1'b0);
        exc_req_i = 1'b0; stall_i = 1'b0;
        step(); expect_state("post_exc", 32'h4184, 1'b0, 1'b0, 1'b0);

        // Exception beats ERET; then ERET alone.
        exc_req_i = 1'b1; eret_req_i = 1'b1; epc_i = 32'h3040;
        step(); expect_state("exc_eret", 32'h4180, 1'b0, 1'b1, 1'b0);
        exc_req_i = 1'b0;
        step(); expect_state("eret", 32'h3040, 1'b0, 1'b1, 1'b0);
        eret_req_i = 1'b0;
        step(); expect_state("post_eret", 32'h3044, 1'b0, 1'b0, 1'b0);

        // Misaligned target loads as-is and raises adel.
        redirect_i = 1'b1; redirect_target_i = 32'h3102;
        step(); expect_state("misalign", 32'h3102, 1'b0, 1'b0, 1'b1);

        // Wrap at the top of the address space.
        redirect_target_i = 32'hFFFF_FFFC;
        step(); expect_state("top", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        redirect_i = 1'b0;
        step(); expect_state("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        step(); check("wrap_next.pc", pc_o, 32'h0000_0004);

        // ERET ignores stall.
        stall_i = 1'b1; eret_req_i = 1'b1; epc_i = 32'h3080;
        step(); expect_state("eret_stall", 32'h3080, 1'b0, 1'b1, 1'b0);
        eret_req_i = 1'b0;
        step(); expect_state("stall_hold", 32'h3080, 1'b0, 1'b0, 1'b0);

        // Reset mid-HOLD discards the pending target.
        redirect_i = 1'b1; redirect_target_i = 32'h3600;
        step(); check("pre_rst.pending", {31'b0, pending_o}, 32'h1);
        redirect_i = 1'b0; reset = 1'b1;
        step(); expect_state("rst_hold", 32'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; stall_i = 1'b0;
        step(); expect_state("post_rst", 32'h3004, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
